// File: rtl/zoom_bist_pkg.sv
// zoom_bist_pkg: shared mode encodings, FSM states and the sweep data pattern
package zoom_bist_pkg;
  localparam logic [1:0] MODE_DOWN      = 2'd0;
  localparam logic [1:0] MODE_ADDR      = 2'd1;
  localparam logic [1:0] MODE_CHECK     = 2'd2;
  localparam logic [1:0] MODE_CHECK_INV = 2'd3;
  localparam int PAT_W = 64;
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_GAP, S_READ, S_DRAIN, S_DONE} state_e;
  // Pattern is built wide and truncated by the caller; odd selects the phase
  // that keeps a '1' in the MSB for odd data widths.
  function automatic logic [PAT_W-1:0] pat_f(input logic [1:0] mode, input logic [PAT_W-1:0] addr,
                                             input logic [PAT_W-1:0] ch, input logic odd);
    logic [PAT_W-1:0] chk;
    chk = (odd ? {32{2'b01}} : {32{2'b10}}) ^ {PAT_W{addr[0]}};
    return (mode == MODE_DOWN ? ~addr : mode == MODE_ADDR ? addr : mode == MODE_CHECK ? chk : ~chk) ^ ch;
  endfunction
endpackage

// File: rtl/zoom_bist_checker.sv
// zoom_bist_checker: latency-aligned read-back compare with error capture
module zoom_bist_checker
  import zoom_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 2,
  parameter int RD_LATENCY = 2,
  parameter int ERR_CNT_W  = 3
) (
  input  logic                           clk,
  input  logic                           tb_rst,
  input  logic                           clr,
  input  logic                           fin,
  input  logic [1:0]                     mode,
  input  logic                           rd_vld,
  input  logic [ADDR_WIDTH-1:0]          rd_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   rd_data,
  output logic [ERR_CNT_W-1:0]           err_cnt,
  output logic [ADDR_WIDTH-1:0]          first_err_addr,
  output logic [NUM_CH-1:0]              err_ch_mask,
  output logic                           pass
);
  localparam logic ODD = (DATA_WIDTH % 2) != 0;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [ADDR_WIDTH-1:0] addr_q [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] addr_d [RD_LATENCY];
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0] first_q, first_d;
  logic [NUM_CH-1:0]     mask_q, mask_d, fail;
  logic                  pass_q, pass_d, any;
  // Delay line, per-channel compare and result update
  always_comb begin
    vld_d = {vld_q[RD_LATENCY-1:0], rd_vld} [RD_LATENCY-1:0];
    addr_d[0] = rd_addr;
    for (int i = 1; i < RD_LATENCY; i++) addr_d[i] = addr_q[i-1];
    fail = '0;
    for (int c = 0; c < NUM_CH; c++)
      fail[c] = vld_q[RD_LATENCY-1] && (rd_data[c*DATA_WIDTH +: DATA_WIDTH] !=
                DATA_WIDTH'(pat_f(mode, PAT_W'(addr_q[RD_LATENCY-1]), PAT_W'(c), ODD)));
    any = |fail;
    err_cnt_d = clr ? '0 : (any && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
    first_d   = clr ? '0 : (any && err_cnt_q == '0) ? addr_q[RD_LATENCY-1] : first_q;
    mask_d    = clr ? '0 : mask_q | fail;
    pass_d    = clr ? 1'b0 : fin ? (err_cnt_q == '0) : pass_q;
  end
  // Result and pipeline registers
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      vld_q     <= '0;
      addr_q    <= '{default: '0};
      err_cnt_q <= '0;
      first_q   <= '0;
      mask_q    <= '0;
      pass_q    <= 1'b0;
    end else begin
      vld_q     <= vld_d;
      addr_q    <= addr_d;
      err_cnt_q <= err_cnt_d;
      first_q   <= first_d;
      mask_q    <= mask_d;
      pass_q    <= pass_d;
    end
  end
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_q;
  assign err_ch_mask    = mask_q;
  assign pass           = pass_q;
endmodule

// File: rtl/zoom_ram_bist.sv
// zoom_ram_bist: write/read-back sweep engine for the ZOOM line-buffer RAMs
module zoom_ram_bist
  import zoom_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 2,
  parameter int RD_LATENCY = 2,
  parameter int ERR_CNT_W  = 3
) (
  input  logic                          clk,
  input  logic                          tb_rst,
  input  logic                          start,
  input  logic [1:0]                    mode,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [ERR_CNT_W-1:0]          err_cnt,
  output logic [ADDR_WIDTH-1:0]         first_err_addr,
  output logic [NUM_CH-1:0]             err_ch_mask,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic                          ram_wr_en,
  output logic [NUM_CH*DATA_WIDTH-1:0]  ram_wr_data,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  ram_rd_data
);
  localparam logic ODD = (DATA_WIDTH % 2) != 0;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d, cnt_inc;
  logic [1:0]            mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  busy_q, busy_d, done_q, done_d, wr_en_q, wr_en_d, accept;
  // Next state, sweep counter and registered RAM/handshake outputs
  always_comb begin
    cnt_inc = cnt_q + 1'b1;
    accept  = state_q == S_IDLE && start;
    state_d = state_q;
    cnt_d   = cnt_inc;
    case (state_q)
      S_IDLE:  begin state_d = accept ? S_WRITE : S_IDLE; cnt_d = '0; end
      S_WRITE: state_d = cnt_inc[ADDR_WIDTH] ? S_GAP : S_WRITE;
      S_GAP:   begin state_d = S_READ; cnt_d = '0; end
      S_READ:  begin state_d = cnt_inc[ADDR_WIDTH] ? S_DRAIN : S_READ; cnt_d = cnt_inc[ADDR_WIDTH] ? '0 : cnt_inc; end
      S_DRAIN: state_d = cnt_inc == (ADDR_WIDTH+1)'(RD_LATENCY) ? S_DONE : S_DRAIN;
      default: state_d = S_IDLE;
    endcase
    mode_d  = accept ? mode : mode_q;
    addr_d  = (state_d == S_WRITE || state_d == S_READ) ? cnt_d[ADDR_WIDTH-1:0] : '0;
    wr_en_d = state_d == S_WRITE;
    busy_d  = state_d != S_IDLE;
    done_d  = state_d == S_DONE;
  end
  // FSM and output registers; reset aborts a sweep immediately
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      addr_q  <= '0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  // Write data follows the registered address; zero when not writing
  always_comb begin
    ram_wr_data = '0;
    for (int c = 0; c < NUM_CH; c++)
      ram_wr_data[c*DATA_WIDTH +: DATA_WIDTH] = wr_en_q ?
        DATA_WIDTH'(pat_f(mode_q, PAT_W'(addr_q), PAT_W'(c), ODD)) : '0;
  end
  assign ram_addr  = addr_q;
  assign ram_wr_en = wr_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  zoom_bist_checker #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_CH(NUM_CH),
    .RD_LATENCY(RD_LATENCY), .ERR_CNT_W(ERR_CNT_W)
  ) u_chk (
    .clk(clk), .tb_rst(tb_rst), .clr(accept), .fin(state_q == S_DONE), .mode(mode_q),
    .rd_vld(state_q == S_READ), .rd_addr(addr_q), .rd_data(ram_rd_data),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr), .err_ch_mask(err_ch_mask), .pass(pass)
  );
endmodule

// File: tb/tb_zoom_ram_bist.sv
// tb_zoom_ram_bist: scoreboard bench for the RAM sweep engine (2- and 1-cycle RAMs)
module tb_zoom_ram_bist;
  logic clk, tb_rst, start;
  logic [1:0] mode;
  logic busy, done, pass, wr_en, busy2, done2, pass2, wr_en2;
  logic [2:0] err_cnt, err_cnt2;
  logic [3:0] fea, fea2, addr, addr2;
  logic [1:0] mask, mask2;
  logic [31:0] wd, rd, wd2, rd2;
  logic [31:0] mem1 [16];
  logic [31:0] mem2 [16];
  logic [31:0] r1a, r1b, r2a;
  logic [31:0] wd_log [16];
  logic [3:0]  ad_log [16];
  int fault, tests, fails;
  typedef struct {int dk; logic p; logic [2:0] ec; logic [3:0] fa; logic [1:0] mk;} exp_t;
  exp_t sb[$];

  zoom_ram_bist #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .NUM_CH(2), .RD_LATENCY(2), .ERR_CNT_W(3)) dut (
    .clk(clk), .tb_rst(tb_rst), .start(start), .mode(mode), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_err_addr(fea), .err_ch_mask(mask), .ram_addr(addr),
    .ram_wr_en(wr_en), .ram_wr_data(wd), .ram_rd_data(rd));
  zoom_ram_bist #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .NUM_CH(2), .RD_LATENCY(1), .ERR_CNT_W(3)) dut2 (
    .clk(clk), .tb_rst(tb_rst), .start(start), .mode(mode), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err_cnt2), .first_err_addr(fea2), .err_ch_mask(mask2), .ram_addr(addr2),
    .ram_wr_en(wr_en2), .ram_wr_data(wd2), .ram_rd_data(rd2));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] flt(input logic [31:0] d, input logic [3:0] a);
    logic [31:0] r;
    r = d;
    if (fault == 1 && a == 4'd5) r[19] = 1'b1;
    if (fault == 2) r[15:0] = '0;
    return r;
  endfunction

  function automatic logic [15:0] exp_pat(input logic [1:0] m, input int a, input int ch);
    logic [15:0] p;
    case (m)
      2'd0: p = 16'hFFFF - 16'(a);
      2'd1: p = 16'(a);
      2'd2: p = (a % 2) ? 16'h5555 : 16'hAAAA;
      default: p = (a % 2) ? 16'hAAAA : 16'h5555;
    endcase
    return p ^ 16'(ch);
  endfunction

  // Read-before-write RAM models: 2-cycle (output register) and 1-cycle
  always @(posedge clk) begin
    if (wr_en) mem1[addr] <= wd;
    r1a <= flt(mem1[addr], addr);
    r1b <= r1a;
    if (wr_en2) mem2[addr2] <= wd2;
    r2a <= mem2[addr2];
  end
  assign rd = r1b;
  assign rd2 = r2a;

  task automatic sweep(input logic [1:0] m, input bit repulse, output int dk, output int dk2, output int nd, output int nw);
    dk = -1; dk2 = -1; nd = 0; nw = 0;
    @(negedge clk); mode = m; start = 1;
    @(negedge clk); start = 0;
    for (int k = 0; k < 60; k++) begin
      if (wr_en && nw < 16) begin wd_log[nw] = wd; ad_log[nw] = addr; nw++; end
      if (done) begin nd++; if (dk < 0) dk = k; end
      if (done2 && dk2 < 0) dk2 = k;
      start = repulse && (k == 3 || k == 20);
      if (repulse && k == 3) mode = 2'd1;
      @(negedge clk);
    end
    start = 0;
  endtask

  task automatic test_reset;
    tb_rst = 1; start = 0; mode = 0; fault = 0;
    repeat (3) @(negedge clk);
    tests++; if ({busy, done, pass, wr_en} !== 4'b0) begin fails++; $display("FAIL reset_ctrl got=%b exp=0000", {busy, done, pass, wr_en}); end
    tests++; if ({err_cnt, fea, mask, addr} !== 13'b0) begin fails++; $display("FAIL reset_status got=%h exp=0", {err_cnt, fea, mask, addr}); end
    tests++; if (wd !== 32'h0) begin fails++; $display("FAIL reset_wd got=%h exp=0", wd); end
    tb_rst = 0;
    repeat (9) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_mode0;
    int dk, dk2, nd, nw;
    exp_t e;
    sb.push_back('{35, 1'b1, 3'd0, 4'd0, 2'b00});
    sweep(2'd0, 0, dk, dk2, nd, nw);
    e = sb.pop_front();
    tests++; if (nw !== 16) begin fails++; $display("FAIL m0_nwrites got=%0d exp=16", nw); end
    for (int i = 0; i < 16; i++) begin
      tests++; if (ad_log[i] !== 4'(i) || wd_log[i] !== {exp_pat(0, i, 1), exp_pat(0, i, 0)}) begin
        fails++; $display("FAIL m0_write[%0d] got=%h/%h exp=%h/%h", i, ad_log[i], wd_log[i], 4'(i), {exp_pat(0, i, 1), exp_pat(0, i, 0)}); end
    end
    tests++; if (dk !== e.dk || nd !== 1) begin fails++; $display("FAIL m0_done got=%0d/%0d exp=%0d/1", dk, nd, e.dk); end
    tests++; if ({pass, err_cnt, fea, mask} !== {e.p, e.ec, e.fa, e.mk}) begin
      fails++; $display("FAIL m0_result got=%b exp=%b", {pass, err_cnt, fea, mask}, {e.p, e.ec, e.fa, e.mk}); end
  endtask

  task automatic test_stuck_bit;
    int dk, dk2, nd, nw;
    exp_t e;
    fault = 1;
    sb.push_back('{35, 1'b0, 3'd1, 4'd5, 2'b10});
    sweep(2'd2, 0, dk, dk2, nd, nw);
    e = sb.pop_front();
    fault = 0;
    tests++; if (dk !== e.dk) begin fails++; $display("FAIL stuck_done got=%0d exp=%0d", dk, e.dk); end
    tests++; if ({pass, err_cnt, fea, mask} !== {e.p, e.ec, e.fa, e.mk}) begin
      fails++; $display("FAIL stuck_result got=%b exp=%b", {pass, err_cnt, fea, mask}, {e.p, e.ec, e.fa, e.mk}); end
  endtask

  task automatic test_saturate;
    int dk, dk2, nd, nw;
    exp_t e;
    fault = 2;
    sb.push_back('{35, 1'b0, 3'd7, 4'd1, 2'b01});
    sweep(2'd1, 0, dk, dk2, nd, nw);
    e = sb.pop_front();
    fault = 0;
    tests++; if (dk !== e.dk) begin fails++; $display("FAIL sat_done got=%0d exp=%0d", dk, e.dk); end
    tests++; if ({pass, err_cnt, fea, mask} !== {e.p, e.ec, e.fa, e.mk}) begin
      fails++; $display("FAIL sat_result got=%b exp=%b", {pass, err_cnt, fea, mask}, {e.p, e.ec, e.fa, e.mk}); end
  endtask

  task automatic test_back_to_back;
    int dk, dk2, nd, nw;
    exp_t e;
    sb.push_back('{35, 1'b1, 3'd0, 4'd0, 2'b00});
    sweep(2'd0, 1, dk, dk2, nd, nw);
    e = sb.pop_front();
    tests++; if (dk !== e.dk || nd !== 1) begin fails++; $display("FAIL restart_done got=%0d/%0d exp=%0d/1", dk, nd, e.dk); end
    tests++; if ({pass, err_cnt, fea, mask} !== {e.p, e.ec, e.fa, e.mk}) begin
      fails++; $display("FAIL restart_result got=%b exp=%b", {pass, err_cnt, fea, mask}, {e.p, e.ec, e.fa, e.mk}); end
  endtask

  task automatic test_abort;
    int dk, dk2, nd, nw, nd_idle;
    exp_t e;
    fault = 2;
    @(negedge clk); mode = 2'd1; start = 1;
    @(negedge clk); start = 0;
    repeat (25) @(negedge clk);
    tests++; if (addr !== 4'd8 || wr_en !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL abort_pos got=%0d/%b/%b exp=8/0/1", addr, wr_en, busy); end
    tests++; if (err_cnt !== 3'd5) begin fails++; $display("FAIL abort_precnt got=%0d exp=5", err_cnt); end
    tb_rst = 1;
    #1;
    tests++; if ({wr_en, busy, done, err_cnt} !== 6'b0) begin fails++; $display("FAIL abort_async got=%b exp=000000", {wr_en, busy, done, err_cnt}); end
    @(negedge clk); tb_rst = 0; fault = 0;
    nd_idle = 0;
    for (int k = 0; k < 40; k++) begin if (done || busy) nd_idle++; @(negedge clk); end
    tests++; if (nd_idle !== 0) begin fails++; $display("FAIL abort_nodone got=%0d exp=0", nd_idle); end
    sb.push_back('{35, 1'b1, 3'd0, 4'd0, 2'b00});
    sweep(2'd0, 0, dk, dk2, nd, nw);
    e = sb.pop_front();
    tests++; if (dk !== e.dk || {pass, err_cnt, mask} !== {e.p, e.ec, e.mk}) begin
      fails++; $display("FAIL abort_rerun got=%0d/%b exp=%0d/%b", dk, {pass, err_cnt, mask}, e.dk, {e.p, e.ec, e.mk}); end
  endtask

  task automatic test_rl1;
    int dk, dk2, nd, nw;
    exp_t e;
    sb.push_back('{34, 1'b1, 3'd0, 4'd0, 2'b00});
    sweep(2'd3, 0, dk, dk2, nd, nw);
    e = sb.pop_front();
    tests++; if (dk2 !== e.dk) begin fails++; $display("FAIL rl1_done got=%0d exp=%0d", dk2, e.dk); end
    tests++; if ({pass2, err_cnt2, fea2, mask2} !== {e.p, e.ec, e.fa, e.mk}) begin
      fails++; $display("FAIL rl1_result got=%b exp=%b", {pass2, err_cnt2, fea2, mask2}, {e.p, e.ec, e.fa, e.mk}); end
    tests++; if (dk !== 35 || pass !== 1'b1) begin fails++; $display("FAIL rl2_mode3 got=%0d/%b exp=35/1", dk, pass); end
  endtask

  initial begin
    tests = 0; fails = 0;
    test_reset;
    test_mode0;
    test_stuck_bit;
    test_saturate;
    test_back_to_back;
    test_abort;
    test_rl1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/zoom_ram_bist.md
Name: zoom_ram_bist

Overview:
- Synthesisable, parametrised self-checking sweep engine for the ZOOM line-buffer RAMs (single-port, read-before-write, optional output register).
- Writes a selectable data pattern to every address of NUM_CH parallel RAMs, reads every address back, and compares against a latency-aligned expected value.
- Reports pass/fail, a saturating error count, the first failing address and which channels failed.
- Used at power-up and on demand from the control plane.

Parameters:
- ADDR_WIDTH, 11, RAM address width; depth N = 2**ADDR_WIDTH
- DATA_WIDTH, 16, per-channel data width (>= 2)
- NUM_CH, 2, number of RAM channels driven in lockstep (1..8)
- RD_LATENCY, 2, RAM read latency in cycles: 1 = no output register, 2 = output register
- ERR_CNT_W, 3, error counter width

Ports:
- clk  in  1  system clock
- tb_rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a test; ignored while busy
- mode  in  2  pattern select, sampled when start is accepted
- busy  out  1  high while a test is running
- done  out  1  one-cycle pulse at test end
- pass  out  1  valid after done; held until the next accepted start
- err_cnt  out  ERR_CNT_W  mismatch count, saturating
- first_err_addr  out  ADDR_WIDTH  address of the first mismatch
- err_ch_mask  out  NUM_CH  sticky per-channel failure flags
- ram_addr  out  ADDR_WIDTH  shared RAM address
- ram_wr_en  out  1  RAM write enable
- ram_wr_data  out  NUM_CH*DATA_WIDTH  write data; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
- ram_rd_data  in  NUM_CH*DATA_WIDTH  RAM read data, same channel packing

Behaviour:
- Clock clk; reset tb_rst is asynchronous, active-high.
- Reset values: all outputs 0, pass=0, FSM in IDLE. Assertion mid-test aborts immediately: ram_wr_en drops asynchronously and no done pulse is produced.
- FSM states: IDLE, WRITE, GAP, READ, DRAIN, DONE.
  - IDLE -> WRITE on start. This edge clears err_cnt, err_ch_mask, first_err_addr and pass, and latches mode.
  - WRITE: N cycles, ram_wr_en=1, ram_addr = 0..N-1.
  - GAP: 1 cycle, ram_wr_en=0, ram_addr=0.
  - READ: N cycles, ram_addr = 0..N-1, ram_wr_en=0.
  - DRAIN: RD_LATENCY cycles.
  - DONE: 1 cycle, done=1, then -> IDLE.
- busy=1 in every state except IDLE.
- Timing: done is high exactly 2N+1+RD_LATENCY cycles after the first WRITE cycle. The first WRITE cycle is the cycle following the start-sampling edge.
- Address counter: ADDR_WIDTH+1 bits; its terminal count ends each sweep, so there is no wrap ambiguity.
- Pattern P(a) for channel c, computed identically on write and on compare:
  - mode 0 DOWN: all-ones minus a (truncated to DATA_WIDTH).
  - mode 1 ADDR: a, zero-extended or truncated to DATA_WIDTH.
  - mode 2 CHECK: repeating 10 bit pairs from the MSB when a[0]=0, the inverse when a[0]=1.
  - mode 3 CHECK_INV: the inverse of mode 2.
  - Channel c XORs P(a) with c, zero-extended, so channels hold distinct data.
- Compare pipeline: READ-cycle address and valid flag are delayed by RD_LATENCY registers. When the delayed valid is high, ram_rd_data is compared per channel against P(delayed address).
- On any channel mismatch in a cycle:
  - err_cnt increments by 1 per cycle, not per channel, and saturates at all-ones with no wrap.
  - The err_ch_mask bits of the failing channels are set.
  - first_err_addr is captured only when err_cnt was 0.
- pass is set in DONE when err_cnt==0. err_cnt, err_ch_mask, first_err_addr and pass all hold until the next accepted start.
- Simultaneous start with DONE: start is ignored, because busy is still 1.

Decomposition:
- Package zoom_bist_pkg holds:
  - the mode encodings (MODE_DOWN=0, MODE_ADDR=1, MODE_CHECK=2, MODE_CHECK_INV=3);
  - the FSM state enum;
  - a pattern function f(mode, addr, ch) used by both the generator and the checker.
- One sub-module, zoom_bist_checker, owns the RD_LATENCY delay line, the per-channel comparators, the saturating counter and the capture logic.
- The top level holds the FSM, the address counter and write-data generation.

Test Plan:
- Bench setup: ADDR_WIDTH=4 (N=16), NUM_CH=2, RD_LATENCY=2, a behavioural RAM model, and start pulsed 10 cycles after reset release.
- Mode 0, ideal RAM -> 16 writes with ch0 data 0xFFFF..0xFFF0; done 35 cycles after the first WRITE cycle; pass=1, err_cnt=0, err_ch_mask=00.
- Mode 2, ch1 bit 3 stuck-at-1 at address 5 only -> err_cnt=1, first_err_addr=5, err_ch_mask=10, pass=0.
- Mode 1, ch0 returns 0 for all addresses -> ch0 expects a, so addresses 1..15 mismatch; err_cnt saturates at 7; first_err_addr=1; err_ch_mask=01.
- start re-pulsed at cycles 3 and 20 of a running test -> no restart; single done pulse at the original cycle; results unchanged.
- tb_rst asserted during READ at address 8 -> ram_wr_en, busy, done and err_cnt are 0 immediately; a fresh start then completes with pass=1.
- RD_LATENCY=1 build with a matching 1-cycle RAM model, mode 3 -> pass=1; done 34 cycles after the first WRITE cycle.
